// File: rtl/noc_tx_injector.sv
// noc_tx_injector: CPU-to-router injection port for one mesh node.
// CPU words tagged with a destination (x,y) are checked, buffered in a small
// circular FIFO and presented to the router's local input as 64-bit flits
// {dst_x[15:0], dst_y[15:0], payload[31:0]} over a valid/ready handshake.
// Illegal destinations are consumed and counted in a saturating drop counter.
// Optional build macro: NOC_TX_TIMEOUT_EN. It enables a stall timer that
// discards the presented flit after TIMEOUT consecutive refused cycles.
module noc_tx_injector #(
    parameter int DEPTH   = 4,
    parameter int MESH_X  = 3,
    parameter int MESH_Y  = 3,
    parameter int LOCAL_X = 1,
    parameter int LOCAL_Y = 1,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_valid,
    input  logic [31:0]              cpu_data,
    input  logic [15:0]              cpu_dst_x,
    input  logic [15:0]              cpu_dst_y,
    output logic                     cpu_ready,
    output logic [63:0]              flit_out,
    output logic                     flit_valid,
    input  logic                     flit_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [7:0]               drop_cnt,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    // Storage and state
    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_drop;
    logic [63:0]   r_flit;
    state_t        r_state;

    // Combinational helpers
    state_t        w_state_next;
    logic          w_load;
    logic          w_accept;
    logic          w_legal;
    logic          w_push;
    logic          w_pop;
    logic          w_illegal_hs;
    logic          w_empty;
    logic          w_fire;
    logic          w_timeout;
    logic [63:0]   w_head;
    logic [8:0]    w_drop_sum;

    // Occupancy-only ready: a full FIFO refuses even if a pop is coming.
    assign cpu_ready    = (r_count < CW'(DEPTH));
    assign w_accept     = cpu_valid && cpu_ready;

    // Destination must be inside the mesh and must not be this node itself.
    assign w_legal      = (cpu_dst_x != 16'd0) && (cpu_dst_x <= 16'(MESH_X)) &&
                          (cpu_dst_y != 16'd0) && (cpu_dst_y <= 16'(MESH_Y)) &&
                          !((cpu_dst_x == 16'(LOCAL_X)) && (cpu_dst_y == 16'(LOCAL_Y)));

    assign w_push       = w_accept && w_legal;
    assign w_illegal_hs = w_accept && !w_legal;
    assign w_empty      = (r_count == '0);
    assign w_fire       = (r_state == ST_PRESENT) && flit_ready;
    assign w_pop        = w_load;

    // Head is read asynchronously so it can be loaded on the same edge it is
    // needed; the FIFO is small, so this maps to distributed storage.
    assign w_head       = r_mem[r_rd_ptr];

`ifdef NOC_TX_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);
    logic [SW-1:0] r_stall;

    // Discard fires on the TIMEOUT-th consecutive refused presentation cycle.
    assign w_timeout = (r_state == ST_PRESENT) && !flit_ready &&
                       (r_stall == SW'(TIMEOUT - 1));

    // Stall timer: counts refused cycles, cleared by handshake, discard or idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall <= '0;
        end else if ((r_state != ST_PRESENT) || flit_ready || w_timeout) begin
            r_stall <= '0;
        end else begin
            r_stall <= r_stall + SW'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // FIFO data array write (no reset needed: pointers define validity).
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cpu_dst_x, cpu_dst_y, cpu_data};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Illegal-destination and timeout discards can coincide; add both, saturate.
    assign w_drop_sum = {1'b0, r_drop} + {8'd0, w_illegal_hs} + {8'd0, w_timeout};

    // Saturating drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop <= '0;
        end else if (w_drop_sum[8]) begin
            r_drop <= 8'hFF;
        end else begin
            r_drop <= w_drop_sum[7:0];
        end
    end

    // Output FSM state register and flit output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_flit  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_flit <= w_head;
            end
        end
    end

    // Next-state: load the head when idle, or on handshake/discard when more is queued.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_load       = 1'b1;
                    w_state_next = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (w_fire || w_timeout) begin
                    if (!w_empty) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign flit_out   = r_flit;
    assign flit_valid = (r_state == ST_PRESENT);
    assign fifo_count = r_count;
    assign drop_cnt   = r_drop;
    assign busy       = (r_count != '0) || flit_valid;

endmodule

// File: tb/tb_noc_tx_injector.sv
// Directed testbench for noc_tx_injector (DEPTH=4, 3x3 mesh, node (1,1)).
module tb_noc_tx_injector;

    logic        clk;
    logic        rst;
    logic        cpu_valid;
    logic [31:0] cpu_data;
    logic [15:0] cpu_dst_x;
    logic [15:0] cpu_dst_y;
    logic        cpu_ready;
    logic [63:0] flit_out;
    logic        flit_valid;
    logic        flit_ready;
    logic [2:0]  fifo_count;
    logic [7:0]  drop_cnt;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    noc_tx_injector #(
        .DEPTH  (4),
        .MESH_X (3),
        .MESH_Y (3),
        .LOCAL_X(1),
        .LOCAL_Y(1),
        .TIMEOUT(64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_valid (cpu_valid),
        .cpu_data  (cpu_data),
        .cpu_dst_x (cpu_dst_x),
        .cpu_dst_y (cpu_dst_y),
        .cpu_ready (cpu_ready),
        .flit_out  (flit_out),
        .flit_valid(flit_valid),
        .flit_ready(flit_ready),
        .fifo_count(fifo_count),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [15:0] x, input logic [15:0] y);
        cpu_valid = v;
        cpu_data  = d;
        cpu_dst_x = x;
        cpu_dst_y = y;
    endtask

    logic [31:0] fill_d [6] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002,
                                32'h4444_0003, 32'h5555_0004, 32'h6666_0005};
    logic [15:0] fill_x [6] = '{16'd2, 16'd3, 16'd1, 16'd2, 16'd3, 16'd2};
    logic [15:0] fill_y [6] = '{16'd1, 16'd1, 16'd2, 16'd2, 16'd3, 16'd3};
    logic [63:0] fill_f [5] = '{64'h0002_0001_1111_0000, 64'h0003_0001_2222_0001,
                                64'h0001_0002_3333_0002, 64'h0002_0002_4444_0003,
                                64'h0003_0003_5555_0004};
    logic [15:0] bad_x  [4] = '{16'd0, 16'd4, 16'd1, 16'd1};
    logic [15:0] bad_y  [4] = '{16'd1, 16'd1, 16'd4, 16'd1};

    initial begin
        rst        = 1'b0;
        flit_ready = 1'b0;
        drive(1'b0, 32'd0, 16'd0, 16'd0);

        // Reset state
        repeat (2) tick();
        chk("rst_flit_valid", 64'(flit_valid), 64'd0);
        chk("rst_flit_out",   flit_out,        64'd0);
        chk("rst_fifo_count", 64'(fifo_count), 64'd0);
        chk("rst_drop_cnt",   64'(drop_cnt),   64'd0);
        chk("rst_busy",       64'(busy),       64'd0);
        rst = 1'b1;
        tick();
        chk("rst_cpu_ready",  64'(cpu_ready),  64'd1);

        // Single send to (3,2)
        flit_ready = 1'b1;
        drive(1'b1, 32'h0000_00AA, 16'd3, 16'd2);
        tick();
        drive(1'b0, 32'd0, 16'd0, 16'd0);
        chk("single_count_after_accept", 64'(fifo_count), 64'd1);
        chk("single_valid_after_accept", 64'(flit_valid), 64'd0);
        tick();
        chk("single_valid", 64'(flit_valid), 64'd1);
        chk("single_flit",  flit_out,        64'h0003_0002_0000_00AA);
        tick();
        chk("single_valid_drop", 64'(flit_valid), 64'd0);
        chk("single_busy_drop",  64'(busy),       64'd0);
        chk("single_flit_hold",  flit_out,        64'h0003_0002_0000_00AA);

        // Backpressure fill: 6 offered, 5 accepted
        flit_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, fill_d[i], fill_x[i], fill_y[i]);
            chk($sformatf("fill_ready_%0d", i), 64'(cpu_ready), (i < 5) ? 64'd1 : 64'd0);
            tick();
        end
        drive(1'b0, 32'd0, 16'd0, 16'd0);
        chk("fill_count", 64'(fifo_count), 64'd4);
        chk("fill_valid", 64'(flit_valid), 64'd1);

        // Stability while refused, then drain in order
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("stall_flit_%0d", i), flit_out, fill_f[0]);
            tick();
        end
        flit_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("drain_valid_%0d", k), 64'(flit_valid), 64'd1);
            chk($sformatf("drain_flit_%0d", k),  flit_out,        fill_f[k]);
            tick();
        end
        chk("drain_valid_end", 64'(flit_valid), 64'd0);
        chk("drain_count_end", 64'(fifo_count), 64'd0);

        // Illegal destinations at node (1,1)
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hDEAD_0000 + 32'(i), bad_x[i], bad_y[i]);
            chk($sformatf("illegal_ready_%0d", i), 64'(cpu_ready), 64'd1);
            tick();
            chk($sformatf("illegal_valid_%0d", i), 64'(flit_valid), 64'd0);
        end
        drive(1'b0, 32'd0, 16'd0, 16'd0);
        chk("illegal_drop4", 64'(drop_cnt),   64'd4);
        chk("illegal_count", 64'(fifo_count), 64'd0);

        // Saturation: 300 more illegal words
        drive(1'b1, 32'h0, 16'd0, 16'd0);
        repeat (100) tick();
        chk("drop_104", 64'(drop_cnt), 64'd104);
        repeat (200) tick();
        drive(1'b0, 32'd0, 16'd0, 16'd0);
        chk("drop_sat", 64'(drop_cnt), 64'd255);

        // Simultaneous push and pop at fifo_count=2
        flit_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0000_00A0 + 32'(i), 16'd2, 16'd1);
            tick();
        end
        chk("pp_count_before", 64'(fifo_count), 64'd2);
        chk("pp_flit_before",  flit_out,        64'h0002_0001_0000_00A0);
        flit_ready = 1'b1;
        drive(1'b1, 32'h0000_00A3, 16'd2, 16'd1);
        tick();
        chk("pp_count_after", 64'(fifo_count), 64'd2);
        chk("pp_flit_after",  flit_out,        64'h0002_0001_0000_00A1);
        flit_ready = 1'b0;
        drive(1'b1, 32'h0000_00A4, 16'd2, 16'd1);
        tick();
        drive(1'b0, 32'd0, 16'd0, 16'd0);
        chk("mid_count3", 64'(fifo_count), 64'd3);
        chk("mid_valid",  64'(flit_valid), 64'd1);

        // Asynchronous reset between edges
        #2;
        rst = 1'b0;
        #1;
        chk("arst_flit_valid", 64'(flit_valid), 64'd0);
        chk("arst_flit_out",   flit_out,        64'd0);
        chk("arst_fifo_count", 64'(fifo_count), 64'd0);
        chk("arst_drop_cnt",   64'(drop_cnt),   64'd0);
        chk("arst_busy",       64'(busy),       64'd0);
        chk("arst_cpu_ready",  64'(cpu_ready),  64'd1);
        rst = 1'b1;
        tick();
        flit_ready = 1'b1;
        drive(1'b1, 32'h1234_5678, 16'd2, 16'd2);
        tick();
        drive(1'b0, 32'd0, 16'd0, 16'd0);
        tick();
        chk("post_rst_valid", 64'(flit_valid), 64'd1);
        chk("post_rst_flit",  flit_out,        64'h0002_0002_1234_5678);
        tick();
        chk("post_rst_idle",  64'(flit_valid), 64'd0);

        // Long stall: two words queued, router refuses
        flit_ready = 1'b0;
        drive(1'b1, 32'h0000_0B01, 16'd3, 16'd3);
        tick();
        drive(1'b1, 32'h0000_0B02, 16'd1, 16'd3);
        tick();
        drive(1'b0, 32'd0, 16'd0, 16'd0);
        chk("stall_first", flit_out, 64'h0003_0003_0000_0B01);
`ifdef NOC_TX_TIMEOUT_EN
        repeat (63) tick();
        chk("to_still_valid", 64'(flit_valid), 64'd1);
        chk("to_still_flit",  flit_out,        64'h0003_0003_0000_0B01);
        chk("to_no_drop_yet", 64'(drop_cnt),   64'd0);
        tick();
        chk("to_next_valid",  64'(flit_valid), 64'd1);
        chk("to_next_flit",   flit_out,        64'h0001_0003_0000_0B02);
        chk("to_drop1",       64'(drop_cnt),   64'd1);
`else
        repeat (210) tick();
        chk("hold_valid", 64'(flit_valid), 64'd1);
        chk("hold_flit",  flit_out,        64'h0003_0003_0000_0B01);
        chk("hold_drop",  64'(drop_cnt),   64'd0);
        chk("hold_count", 64'(fifo_count), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
